inv_sub_bytes_iter: RTL
=======================

# inv_sub_bytes_iter

Iterative inverse SubBytes stage for the AES decryption datapath. It sits directly downstream of the inverse ShiftRows stage. It takes a 128-bit state, replaces every byte with its inverse S-box value, and processes a configurable number of bytes per cycle to trade area for latency. A valid/ready handshake on both sides lets it pace the registered inverse ShiftRows output and feed AddRoundKey.

## Interface
- BYTES_PER_CYCLE, 4, number of inverse S-box lookups per cycle; legal values 1, 2, 4, 8, 16.
- clk  input  1  rising-edge clock; all state changes on this edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  data_in holds a state to be substituted.
- in_ready  output  1  block can accept a state this cycle.
- data_in  input  128  input state; byte 0 = [127:120], byte 15 = [7:0] (column-major, same packing as the ShiftRows stages).
- out_valid  output  1  data_out holds a completed result.
- out_ready  input  1  downstream accepts data_out this cycle.
- data_out  output  128  substituted state, same byte packing; valid only while out_valid = 1.

## Operation
- N = 16 / BYTES_PER_CYCLE groups; group g = bytes g·B … g·B+B−1, processed from byte 0 (MSB) first.
- Registers: 128-bit work register, group counter (log2(N) bits, min 1 bit), 2-bit FSM.
- FSM states:
  - IDLE: in_ready = 1, out_valid = 0. On in_valid, load data_in into the work register, clear the counter and go to BUSY.
  - BUSY: in_ready = 0, out_valid = 0. Each cycle, replace group[counter] in place with InvSbox(byte) and increment the counter. The group with counter = N−1 transitions to DONE.
  - DONE: out_valid = 1, data_out = work register. If out_ready = 0, hold everything. If out_ready = 1 and in_valid = 0, go to IDLE. If out_ready = 1 and in_valid = 1, load data_in, clear the counter and go to BUSY (back-to-back).
- in_ready = (FSM == IDLE) | (FSM == DONE & out_ready). This is combinational from out_ready and the only combinational input-to-output path.
- InvSbox is the full 256-entry FIPS-197 inverse S-box, held as constant combinational logic. B copies are instantiated.
- data_out is driven directly from the work register, with no extra output register.
- in_valid is ignored outside the accept conditions above. in_valid = 1 in BUSY does not disturb the operation.
- Bytes already substituted are never substituted again. A group is written exactly once per accepted state.

## Timing
- Reset (async assert, sync release): FSM = IDLE, counter = 0, work register = 0, out_valid = 0, data_out = 0. While rst = 1, in_ready reads 1 but no capture occurs.
- Reset asserted in BUSY or DONE aborts the operation immediately. The in-flight result is discarded and not presented.
- Latency: a state accepted at edge k gives out_valid = 1 from edge k+N (B = 4 gives 4 cycles; B = 16 gives 1 cycle).
- Throughput: one state per N+1 cycles with out_ready held high. Back-to-back acceptance in DONE removes the IDLE bubble, so throughput is one state per N cycles, plus the DONE cycle.
- Stall: data_out and out_valid stay constant while out_valid = 1 and out_ready = 0, for any number of cycles.
- The counter wraps only via reload. It never increments outside BUSY.

## Test plan
- Reset mid-BUSY: accept a state, assert rst after 2 cycles -> out_valid = 0, data_out = 0, in_ready = 1. A later state still processes correctly.
- Known vector (B = 4): data_in = 7a9f102789d5f50b2beffd9f3dca4ea7 -> after 4 cycles, out_valid = 1 and data_out = bd6e7c3df2b5779e0b61216e8b10b689 (FIPS-197 C.1 round 1 is_box).
- Boundary bytes, repeated for B = 1, 2, 8, 16 with latency checked at 16, 8, 2, 1:
  - all-0x63 -> all-0x00
  - all-0x00 -> all-0x52
  - all-0x16 -> all-0xff
- Backpressure: hold out_ready = 0 for 10 cycles after completion -> data_out stable, in_ready = 0, and an in_valid pulse is not captured. Releasing out_ready completes the transfer in one cycle.
- Back-to-back: in_valid and out_ready held high with two distinct states -> the second state is accepted in the DONE cycle of the first. Outputs appear N+1 cycles apart with no intervening IDLE cycle.
- Random: 1000 random states with random in_valid/out_ready gaps, checked against a reference model -> every output matches, order is preserved, and nothing is dropped or duplicated.

Source files
------------

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES inverse SubBytes: replaces the 16 state bytes with their inverse S-box values,
// BYTES_PER_CYCLE bytes per cycle, behind valid/ready handshakes on both sides.
module inv_sub_bytes_iter #(
    parameter int unsigned BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    localparam int unsigned NumGroups = 16 / BYTES_PER_CYCLE;
    localparam int unsigned CntW      = (NumGroups > 1) ? $clog2(NumGroups) : 1;
    localparam int unsigned GroupW    = 8 * BYTES_PER_CYCLE;
    localparam logic [CntW-1:0] LastCnt = CntW'(NumGroups - 1);

    // Entry 0x00 sits in the top byte, so byte b lives at bit offset 8 * (255 - b) = {~b, 000}.
    localparam logic [2047:0] InvSbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return InvSbox[{~b, 3'b000} +: 8];
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [127:0]        work_q, work_d;
    logic [GroupW-1:0]   group_in, group_out;

    // Group 0 is the most significant slice of the state.
    assign group_in = work_q[127 - GroupW * 32'(cnt_q) -: GroupW];

    for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_sbox
        assign group_out[GroupW - 1 - 8 * j -: 8] = inv_sbox(group_in[GroupW - 1 - 8 * j -: 8]);
    end

    assign data_out = work_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_d  = data_in;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                work_d[127 - GroupW * 32'(cnt_q) -: GroupW] = group_out;
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        // Back-to-back: take the next state in the same cycle the result leaves.
                        work_d  = data_in;
                        cnt_d   = '0;
                        state_d = StBusy;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

endmodule
